// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: register address
// width, RAM op codes, pause polarity and controller state encodings.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic RAM_OP_RD = 1'b0;
  localparam logic RAM_OP_WR = 1'b1;

  localparam logic PAUSE_ENABLE  = 1'b1;
  localparam logic PAUSE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: the instruction in EXE is a load whose destination
// is a source that the instruction in ID actually reads.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic                  rs_use,
  input  logic                  rt_use,
  input  logic                  ram_en,
  input  logic                  ram_op,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  load_use
);

  assign load_use = ram_en && (ram_op == RAM_OP_RD) &&
                    ((rs_use && (rs_addr == wb_addr)) ||
                     (rt_use && (rt_addr == wb_addr)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, shared-RAM wait with
// timeout, and branch flushes, plus a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  rst,
  input  logic                  clk_50MHz,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_rs_use,
  input  logic                  id_rt_use,
  input  logic                  ie_RAM_en,
  input  logic                  ie_RAM_op,
  input  logic [REG_ADDR_W-1:0] ie_wb_addr,
  input  logic                  ie_jump_taken,
  input  logic                  em_RAM_en,
  input  logic                  mem_ack,
  output logic                  pc_PAUSE,
  output logic                  if_PAUSE,
  output logic                  ie_PAUSE,
  output logic                  em_PAUSE,
  output logic                  jump_control_ie_PAUSE,
  output logic                  if_FLUSH,
  output logic                  mem_timeout,
  output logic [15:0]           stall_cnt
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  ctrl_state_t state, state_next;
  logic [3:0]  wait_cnt;
  logic        jump_pending;
  logic        jump_req;
  logic        load_use;
  logic        timeout_hit;

  hazard_detect u_hazard_detect (
    .rs_addr (id_rs_addr),
    .rt_addr (id_rt_addr),
    .rs_use  (id_rs_use),
    .rt_use  (id_rt_use),
    .ram_en  (ie_RAM_en),
    .ram_op  (ie_RAM_op),
    .wb_addr (ie_wb_addr),
    .load_use(load_use)
  );

  // A jump that was parked behind a memory wait is replayed as if it had just resolved.
  assign jump_req = ie_jump_taken || jump_pending;

  always_comb begin
    state_next            = state;
    pc_PAUSE              = PAUSE_DISABLE;
    if_PAUSE              = PAUSE_DISABLE;
    ie_PAUSE              = PAUSE_DISABLE;
    em_PAUSE              = PAUSE_DISABLE;
    jump_control_ie_PAUSE = PAUSE_DISABLE;
    if_FLUSH              = 1'b0;
    timeout_hit           = 1'b0;
    unique case (state)
      RUN, LU_STALL: begin
        if (em_RAM_en) begin
          pc_PAUSE   = PAUSE_ENABLE;
          if_PAUSE   = PAUSE_ENABLE;
          ie_PAUSE   = PAUSE_ENABLE;
          em_PAUSE   = PAUSE_ENABLE;
          state_next = MEM_WAIT;
        end else if (jump_req) begin
          if_FLUSH              = 1'b1;
          jump_control_ie_PAUSE = PAUSE_ENABLE;
          state_next            = FLUSH;
        end else if (state == RUN && load_use) begin
          pc_PAUSE              = PAUSE_ENABLE;
          if_PAUSE              = PAUSE_ENABLE;
          jump_control_ie_PAUSE = PAUSE_ENABLE;
          state_next            = LU_STALL;
        end else begin
          state_next = RUN;
        end
      end
      MEM_WAIT: begin
        pc_PAUSE = PAUSE_ENABLE;
        if_PAUSE = PAUSE_ENABLE;
        ie_PAUSE = PAUSE_ENABLE;
        em_PAUSE = PAUSE_ENABLE;
        if (mem_ack) begin
          state_next = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = RUN;
        end
      end
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
    // Decoded outputs must read idle while reset is held, whatever the inputs.
    if (!rst) begin
      pc_PAUSE              = PAUSE_DISABLE;
      if_PAUSE              = PAUSE_DISABLE;
      ie_PAUSE              = PAUSE_DISABLE;
      em_PAUSE              = PAUSE_DISABLE;
      jump_control_ie_PAUSE = PAUSE_DISABLE;
      if_FLUSH              = 1'b0;
      timeout_hit           = 1'b0;
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      wait_cnt     <= 4'd0;
      jump_pending <= 1'b0;
      mem_timeout  <= 1'b0;
      stall_cnt    <= 16'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == MEM_WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (em_PAUSE && ie_jump_taken)
        jump_pending <= 1'b1;
      else if (if_FLUSH)
        jump_pending <= 1'b0;
      if (timeout_hit)
        mem_timeout <= 1'b1;
      if (pc_PAUSE && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of MEM_WAIT cycles before abort (range 1..15).
REQ-002 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port clk_50MHz  in  1  pipeline clock, rising edge.
REQ-004 SHALL have port id_rs_addr  in  REG_ADDR_BUS  first source register of the instruction in ID.
REQ-005 SHALL have port id_rt_addr  in  REG_ADDR_BUS  second source register of the instruction in ID.
REQ-006 SHALL have port id_rs_use, id_rt_use  in  1 each  source-read valid flags.
REQ-007 SHALL have port ie_RAM_en, ie_RAM_op  in  1 each  EXE-stage memory enable and op (RAM_OP_RD = load).
REQ-008 SHALL have port ie_wb_addr  in  REG_ADDR_BUS  EXE-stage destination register.
REQ-009 SHALL have port ie_jump_taken  in  1  branch/jump resolved taken in EXE.
REQ-010 SHALL have port em_RAM_en  in  1  MEM stage accesses the shared instruction/data RAM.
REQ-011 SHALL have port mem_ack  in  1  RAM controller completion strobe (one cycle).
REQ-012 SHALL have port pc_PAUSE, if_PAUSE, ie_PAUSE, em_PAUSE  out  1 each  hold PC, IF/ID, ID/EXE, EXE/MEM.
REQ-013 SHALL have port jump_control_ie_PAUSE  out  1  insert a bubble into ID/EXE.
REQ-014 SHALL have port if_FLUSH  out  1  replace IF/ID contents with NOP.
REQ-015 SHALL have port mem_timeout  out  1  sticky abort flag.
REQ-016 SHALL have port stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-017 SHALL implement FSM states RUN, LU_STALL, MEM_WAIT, FLUSH; all outputs registered except the pause/flush outputs, which SHALL be decoded combinationally from state plus inputs (no added latency).
REQ-018 SHALL detect a load-use hazard when ie_RAM_en=1, ie_RAM_op=RD, and (id_rs_use and id_rs_addr==ie_wb_addr, or id_rt_use and id_rt_addr==ie_wb_addr).
REQ-019 In RUN, a load-use hazard SHALL assert pc_PAUSE, if_PAUSE and jump_control_ie_PAUSE for exactly one cycle, then go to LU_STALL and return to RUN on the next cycle.
REQ-020 In RUN, em_RAM_en=1 SHALL assert pc_PAUSE, if_PAUSE, ie_PAUSE and em_PAUSE (all PAUSE_ENABLE) and go to MEM_WAIT; MEM_WAIT SHALL hold these until the cycle mem_ack=1, then return to RUN.
REQ-021 MEM_WAIT SHALL count cycles with a 4-bit counter; on reaching MEM_TIMEOUT without mem_ack it SHALL set mem_timeout and return to RUN.
REQ-022 ie_jump_taken=1 in RUN or LU_STALL SHALL assert if_FLUSH and jump_control_ie_PAUSE for one cycle (FLUSH state), overriding any load-use stall.
REQ-023 Priority for simultaneous events: MEM_WAIT entry > jump flush > load-use; a jump arriving during MEM_WAIT SHALL be held in a pending flag and serviced in the cycle after mem_ack.
REQ-024 mem_ack in RUN SHALL be ignored.
REQ-025 stall_cnt SHALL increment on every cycle pc_PAUSE=1 and saturate at 16'hFFFF.
REQ-026 mem_timeout SHALL stay set until reset.

Reset
REQ-027 On rst=0 SHALL, asynchronously, set state=RUN, wait counter=0, pending jump=0, mem_timeout=0, stall_cnt=0; all pause/flush outputs SHALL read deasserted.
REQ-028 Reset during MEM_WAIT or LU_STALL SHALL abandon the stall with no residual pause.

Structure
REQ-029 State encodings, PAUSE_ENABLE/PAUSE_DISABLE, RAM_OP_RD and REG_ADDR_BUS SHALL live in the shared define.v.
REQ-030 One sub-module, hazard_detect (the combinational load-use comparator), SHALL be instantiated.

Verification
REQ-031 Load R2 in EXE, ID reads R2 as rs -> pc_PAUSE/if_PAUSE/jump_control_ie_PAUSE high 1 cycle, stall_cnt=1.
REQ-032 em_RAM_en=1, mem_ack after 3 cycles -> all four PAUSEs high for 4 cycles, then RUN.
REQ-033 ie_jump_taken=1 together with a load-use hazard -> if_FLUSH=1 and bubble for 1 cycle, no extra stall.
REQ-034 em_RAM_en=1, no mem_ack -> after 15 cycles mem_timeout=1, PAUSEs drop.
REQ-035 rst=0 mid-MEM_WAIT -> all outputs 0 immediately; jump during MEM_WAIT -> if_FLUSH in the cycle after mem_ack.
